// File: rtl/fsqrt_arbiter.sv
// Two-requester round-robin front end for a fixed-latency fsqrt unit, with flush/drain control.
// Optional per-requester issue counters are built only when FSQRT_ARB_STATS_EN is defined.
module fsqrt_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    output logic        req0_grant,
    output logic        req1_grant,
    output logic [31:0] fs_a,
    input  logic [31:0] fs_s,
    output logic        res_valid,
    output logic        res_id,
    output logic [31:0] res_data,
    output logic [1:0]  inflight,
    input  logic        flush,
    output logic        flush_done,
    output logic [15:0] stat0_cnt,
    output logic [15:0] stat1_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } state_t;

    state_t           state_r;
    logic             rr_r;
    logic [LAT-1:0]   tag_v_r;
    logic [LAT-1:0]   tag_id_r;
    logic             issue_ok_s;
    logic             grant_any_s;
    logic             grant_id_s;

    // Grant selection: only in RUN with no flush request, never while reset is held.
    always_comb begin
        req0_grant = 1'b0;
        req1_grant = 1'b0;
        issue_ok_s = !rst && (state_r == RUN) && !flush;
        if (issue_ok_s) begin
            if (req0_valid && req1_valid) begin
                req0_grant = !rr_r;
                req1_grant = rr_r;
            end else begin
                req0_grant = req0_valid;
                req1_grant = req1_valid;
            end
        end else begin
            req0_grant = 1'b0;
            req1_grant = 1'b0;
        end
        grant_any_s = req0_grant || req1_grant;
        grant_id_s  = req1_grant;
    end

    // Operand mux toward the fsqrt unit; zero when nothing is issued.
    always_comb begin
        fs_a = 32'h0000_0000;
        if (req0_grant) begin
            fs_a = req0_a;
        end else if (req1_grant) begin
            fs_a = req1_a;
        end else begin
            fs_a = 32'h0000_0000;
        end
    end

    // Round-robin pointer and the {valid, id} tag shift register that tracks the fsqrt pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_r     <= 1'b0;
            tag_v_r  <= '0;
            tag_id_r <= '0;
        end else begin
            if (grant_any_s) begin
                rr_r <= !grant_id_s;
            end
            tag_v_r[0]  <= grant_any_s;
            tag_id_r[0] <= grant_id_s;
            for (int i = 1; i < LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_id_r[i] <= tag_id_r[i-1];
            end
        end
    end

    // Result capture: fs_s is aligned with the last tag stage; id/data hold between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= 32'h0000_0000;
        end else begin
            res_valid <= tag_v_r[LAT-1];
            if (tag_v_r[LAT-1]) begin
                res_id   <= tag_id_r[LAT-1];
                res_data <= fs_s;
            end
        end
    end

    // Outstanding-operation count: issued but not yet seen on res_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 2'd0;
        end else begin
            case ({grant_any_s, res_valid})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Flush control FSM; flush_done is registered alongside the DRAINED state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            flush_done <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (flush) begin
                        state_r <= DRAIN;
                    end
                    flush_done <= 1'b0;
                end
                DRAIN: begin
                    if (!flush) begin
                        state_r    <= RUN;
                        flush_done <= 1'b0;
                    end else if ((tag_v_r == '0) && (inflight == 2'd0)) begin
                        state_r    <= DRAINED;
                        flush_done <= 1'b1;
                    end else begin
                        flush_done <= 1'b0;
                    end
                end
                DRAINED: begin
                    if (!flush) begin
                        state_r    <= RUN;
                        flush_done <= 1'b0;
                    end else begin
                        flush_done <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef FSQRT_ARB_STATS_EN
    logic [15:0] stat0_r;
    logic [15:0] stat1_r;

    // Saturating per-requester issue counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_r <= 16'h0000;
            stat1_r <= 16'h0000;
        end else begin
            if (req0_grant && (stat0_r != 16'hFFFF)) begin
                stat0_r <= stat0_r + 16'h0001;
            end
            if (req1_grant && (stat1_r != 16'hFFFF)) begin
                stat1_r <= stat1_r + 16'h0001;
            end
        end
    end

    assign stat0_cnt = stat0_r;
    assign stat1_cnt = stat1_r;
`else
    assign stat0_cnt = 16'h0000;
    assign stat1_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Scoreboard bench for fsqrt_arbiter (LAT=2): a cycle model predicts grants, state and
// inflight; expected results are queued at issue and popped when res_valid is due.
module tb_fsqrt_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_a = 32'h0, req1_a = 32'h0;
    logic        req0_grant, req1_grant;
    logic [31:0] fs_a, fs_s;
    logic        res_valid, res_id;
    logic [31:0] res_data;
    logic [1:0]  inflight;
    logic        flush = 1'b0;
    logic        flush_done;
    logic [15:0] stat0_cnt, stat1_cnt;

    int total = 0;
    int bad   = 0;

    fsqrt_arbiter #(.LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a),
        .req1_valid(req1_valid), .req1_a(req1_a),
        .req0_grant(req0_grant), .req1_grant(req1_grant),
        .fs_a(fs_a), .fs_s(fs_s),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
        .inflight(inflight), .flush(flush), .flush_done(flush_done),
        .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fake_sqrt(input logic [31:0] a);
        if (a == 32'h4080_0000) return 32'h4000_0000;
        else if (a == 32'h4110_0000) return 32'h4040_0000;
        else return a ^ 32'h5A5A_0F0F;
    endfunction

    // Stand-in fsqrt unit with a two-cycle pipeline.
    logic [31:0] p1, p2;
    always @(posedge clk) begin
        p1 <= fake_sqrt(fs_a);
        p2 <= p1;
    end
    assign fs_s = p2;

    // Reference model state (values the DUT registers hold during the current cycle).
    logic [1:0]  m_state;
    logic        m_rr, m_t1v, m_t1id, m_t2v, m_t2id, m_rv, m_rid;
    logic [31:0] m_rdata;
    int          m_inflight, m_s0, m_s1;
    logic [32:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 2'd0; m_rr = 1'b0; m_t1v = 1'b0; m_t1id = 1'b0; m_t2v = 1'b0; m_t2id = 1'b0;
        m_rv = 1'b0; m_rid = 1'b0; m_rdata = 32'h0; m_inflight = 0; m_s0 = 0; m_s1 = 0;
        sb.delete();
    endtask

    task automatic check_stats();
`ifdef FSQRT_ARB_STATS_EN
        check_eq("stat0", {16'h0, stat0_cnt}, m_s0);
        check_eq("stat1", {16'h0, stat1_cnt}, m_s1);
`else
        check_eq("stat0", {16'h0, stat0_cnt}, 32'h0);
        check_eq("stat1", {16'h0, stat1_cnt}, 32'h0);
`endif
    endtask

    task automatic step(input logic v0, input logic [31:0] a0, input logic v1,
                        input logic [31:0] a1, input logic fl);
        logic eg0, eg1, egany, egid;
        logic [31:0] efa;
        logic [32:0] item;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req1_valid = v1; req1_a = a1; flush = fl;
        #1;
        eg0 = 1'b0; eg1 = 1'b0;
        if ((m_state == 2'd0) && !fl) begin
            if (v0 && v1) begin eg0 = !m_rr; eg1 = m_rr; end
            else begin eg0 = v0; eg1 = v1; end
        end
        egany = eg0 | eg1;
        egid  = eg1;
        efa   = eg0 ? a0 : (eg1 ? a1 : 32'h0);
        check_eq("req0_grant", {31'h0, req0_grant}, {31'h0, eg0});
        check_eq("req1_grant", {31'h0, req1_grant}, {31'h0, eg1});
        check_eq("fs_a", fs_a, efa);
        check_eq("res_valid", {31'h0, res_valid}, {31'h0, m_rv});
        check_eq("res_id", {31'h0, res_id}, {31'h0, m_rid});
        check_eq("res_data", res_data, m_rdata);
        check_eq("inflight", {30'h0, inflight}, m_inflight);
        check_eq("flush_done", {31'h0, flush_done}, {31'h0, (m_state == 2'd2)});
        check_stats();
        // advance the model to the values expected after the coming edge
        if (egany) sb.push_back({egid, fake_sqrt(efa)});
        case (m_state)
            2'd0:    if (fl) m_state = 2'd1;
            2'd1:    if (!fl) m_state = 2'd0; else if (m_inflight == 0) m_state = 2'd2;
            2'd2:    if (!fl) m_state = 2'd0;
            default: m_state = 2'd0;
        endcase
        if (egany && !m_rv) m_inflight++;
        else if (!egany && m_rv) m_inflight--;
        if (egany) m_rr = !egid;
        if (eg0 && m_s0 < 65535) m_s0++;
        if (eg1 && m_s1 < 65535) m_s1++;
        m_rv = m_t2v;
        if (m_t2v) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'h1, 32'h0);
            end else begin
                item = sb.pop_front();
                m_rid = item[32];
                m_rdata = item[31:0];
            end
        end
        m_t2v = m_t1v; m_t2id = m_t1id;
        m_t1v = egany; m_t1id = egid;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h1234_5678; req1_a = 32'h8765_4321; flush = 1'b0;
        #1;
        check_eq("rst_grant0", {31'h0, req0_grant}, 32'h0);
        check_eq("rst_grant1", {31'h0, req1_grant}, 32'h0);
        check_eq("rst_fs_a", fs_a, 32'h0);
        check_eq("rst_res_valid", {31'h0, res_valid}, 32'h0);
        check_eq("rst_res_id", {31'h0, res_id}, 32'h0);
        check_eq("rst_res_data", res_data, 32'h0);
        check_eq("rst_inflight", {30'h0, inflight}, 32'h0);
        check_eq("rst_flush_done", {31'h0, flush_done}, 32'h0);
        model_reset();
        check_stats();
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        model_reset();
        do_reset();
        idle(1);

        // single request of 4.0
        step(1'b1, 32'h4080_0000, 1'b0, 32'h0, 1'b0);
        idle(4);
        check_eq("sqrt4_data", res_data, 32'h4000_0000);

        // both valid for 6 cycles after reset: alternating grants
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 32'h4110_0000 + i, 1'b1, 32'h3F80_0000 + i, 1'b0);
        idle(5);

        // 3 back-to-back, then flush held with requests pending
        step(1'b1, 32'h4080_0000, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h4110_0000, 1'b0);
        step(1'b1, 32'h4000_0000, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 32'hAAAA_0000, 1'b1, 32'h5555_0000, 1'b1);
        idle(2);

        // flush together with req1 from RUN, then release mid-drain
        step(1'b0, 32'h0, 1'b1, 32'h4080_0000, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h4080_0000, 1'b0);
        step(1'b1, 32'h4110_0000, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h4110_0000, 1'b0, 32'h0, 1'b0);
        idle(4);

        // reset with two operations in flight
        step(1'b1, 32'h0BAD_0001, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h0BAD_0002, 1'b0);
        do_reset();
        idle(4);

        // five grants to req1 for the counters
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 32'h4000_0000 + i, 1'b0);
        idle(4);

        // random traffic with occasional flush windows
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 9) < 2));
        end
        idle(5);
        check_eq("sb_empty", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsqrt_arbiter.md
FSQRT_ARBITER -- requirements
Module: fsqrt_arbiter

Interface
REQ-001 Parameter: LAT, default 2, fixed pipeline latency of the external fsqrt unit in clock cycles.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1 each  requester N has an operand to issue.
REQ-005 req0_a / req1_a  input  32 each  IEEE-754 single operand from requester N.
REQ-006 req0_grant / req1_grant  output  1 each  combinational; operand N is accepted this cycle.
REQ-007 fs_a  output  32  operand to fsqrt input a; combinational mux of the granted operand, 32'h0 when no grant.
REQ-008 fs_s  input  32  fsqrt result s; corresponds to fs_a presented LAT cycles earlier.
REQ-009 res_valid  output  1  registered one-cycle pulse; res_data is valid.
REQ-010 res_id  output  1  registered; requester that owns res_data.
REQ-011 res_data  output  32  registered square-root result.
REQ-012 inflight  output  2  registered count of issued, not yet returned operations (0..LAT+1).
REQ-013 flush  input  1  level request to stop issuing and drain.
REQ-014 flush_done  output  1  registered; high while in DRAINED state.
REQ-015 stat0_cnt / stat1_cnt  output  16 each  per-requester issue counters (see Configuration).

Function
REQ-016 At most one grant per cycle; grant only in state RUN.
REQ-017 Arbitration is round-robin: pointer rr (1 bit) names the preferred requester; if only one requester is valid, it wins regardless of rr.
REQ-018 After a grant to requester N, rr SHALL become !N on the next edge; rr unchanged on cycles without a grant.
REQ-019 Tag pipeline: LAT-stage shift register of {valid, id}; stage 1 loads {grant_any, granted_id} every cycle.
REQ-020 When tag stage LAT is valid, next edge: res_valid=1, res_id=tag id, res_data=fs_s; otherwise res_valid=0 and res_id/res_data hold.
REQ-021 Total latency: grant at edge t sampled -> res_valid high in cycle t+LAT+1 (3 cycles for LAT=2).
REQ-022 Results are never stalled; back-to-back grants give back-to-back res_valid pulses in issue order.
REQ-023 inflight increments on grant, decrements on res_valid; on the same cycle as both it is unchanged.
REQ-024 States: RUN (issue allowed), DRAIN (no grants, wait), DRAINED (flush_done=1).
REQ-025 RUN -> DRAIN when flush=1; grants are suppressed in that same cycle.
REQ-026 DRAIN -> DRAINED when the tag pipeline is empty and no res_valid is pending (inflight=0).
REQ-027 DRAIN or DRAINED -> RUN when flush=0; DRAIN with flush deasserted resumes issuing immediately.
REQ-028 In-flight results during DRAIN are still delivered on res_valid.

Reset
REQ-029 On rst: state=RUN, rr=0, all tag stages invalid, res_valid=0, res_id=0, res_data=0, inflight=0, flush_done=0, stat counters=0.
REQ-030 Reset mid-operation discards all in-flight operations; no res_valid for them after reset releases.
REQ-031 During rst, grants are 0 and fs_a=0.

Configuration
REQ-032 Macro FSQRT_ARB_STATS_EN defined: stat0_cnt/stat1_cnt increment on each grant to the respective requester, saturating at 16'hFFFF.
REQ-033 Macro FSQRT_ARB_STATS_EN undefined: no counter logic; stat0_cnt and stat1_cnt tied to 16'h0.

Verification
REQ-034 req0 alone, a=32'h40800000 (4.0) -> req0_grant same cycle, res_valid 3 cycles later with res_id=0, res_data=32'h40000000.
REQ-035 Both valid every cycle for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; res_id sequence identical; inflight peaks at 3.
REQ-036 Issue 3 back-to-back, assert flush next cycle -> no further grants, 3 res_valid pulses, flush_done rises the cycle after inflight reaches 0.
REQ-037 Assert rst with 2 ops in flight -> outputs at reset values; no res_valid in the 4 cycles after release with requests low.
REQ-038 flush and req1_valid asserted in the same cycle -> req1_grant=0, fs_a=0, state DRAIN.
REQ-039 With FSQRT_ARB_STATS_EN: 5 grants to req1 -> stat1_cnt=5, stat0_cnt=0; without the macro both read 0.
